hist_eq_stream: RTL and testbench

//  Per-frame histogram equalisation on an AXI4-Stream grey video path, no m_axis_tready.
//  - Accumulates the histogram of frame N.
//  - Builds the equalisation LUT during a stall window after the last pixel of frame N.
//  - Maps frame N+1 through that LUT.
//  - Mapped pixel is replicated OUT_CH times on m_axis_tdata, e.g. grey to RGB for display.

---
 rtl/hist_eq_pkg.sv | 18 +
 rtl/hist_eq_lut.sv | 22 ++
 rtl/hist_eq_stream.sv | 134 +++++++++++++
 tb/tb_hist_eq_stream.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hist_eq_pkg.sv
// hist_eq_pkg: state encoding, width/scale helpers and saturation shared by hist_eq_stream
package hist_eq_pkg;
  typedef enum logic [1:0] {WAIT_SOF, ACCUM, CDF, CLR} state_t;
  function automatic int cnt_width(input int total);
    return $clog2(total + 1);
  endfunction
  function automatic longint scale_of(input int dw, input int frac_w, input int total);
    return (((longint'(1) << dw) - 1) << frac_w) / total;
  endfunction
  function automatic int prod_width(input int cnt_w, input longint scale);
    return cnt_w + $clog2(scale + 1);
  endfunction
  function automatic logic [63:0] sat(input logic [63:0] v, input int dw);
    logic [63:0] mx;
    mx = (64'd1 << dw) - 64'd1;
    return v > mx ? mx : v;
  endfunction
endpackage

// File: rtl/hist_eq_lut.sv
// hist_eq_lut: NBINS-entry equalisation LUT, synchronous write, asynchronous read
//   clk_i   clock            we_i/waddr_i/wdata_i  write port
//   raddr_i read address     valid_i               LUT holds a complete table
//   rdata_o mapped value, identity while valid_i is low
module hist_eq_lut
  import hist_eq_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [DW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [DW-1:0] raddr_i,
  input  logic          valid_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**DW];
  always_ff @(posedge clk_i)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = valid_i ? mem_q[raddr_i] : raddr_i;
endmodule

// File: rtl/hist_eq_stream.sv
// hist_eq_stream: per-frame histogram equalisation on an AXI4-Stream grey video path
//   i_sys_clk/i_sys_aresetn  clock, async active-low reset
//   s_axis_*                 input pixel stream (tready drops during LUT build / clear)
//   m_axis_*                 mapped pixel replicated OUT_CH times, 1-cycle latency
//   o_lut_valid              LUT built from at least one full frame
//   o_frame_err              1-cycle pulse when tuser arrives mid-frame
//   i_bypass                 only with HIST_EQ_BYPASS_EN: output raw pixel while high
module hist_eq_stream
  import hist_eq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int OUT_CH     = 3,
  parameter int FRAC_W     = 16
) (
  input  logic                         i_sys_clk,
  input  logic                         i_sys_aresetn,
`ifdef HIST_EQ_BYPASS_EN
  input  logic                         i_bypass,
`endif
  input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tuser,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic [OUT_CH*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  output logic                         m_axis_tuser,
  output logic                         m_axis_tlast,
  output logic                         o_lut_valid,
  output logic                         o_frame_err
);
  localparam int     NBINS = 2**DATA_WIDTH;
  localparam int     TOTAL = IMG_W * IMG_H;
  localparam int     CNT_W = cnt_width(TOTAL);
  localparam longint SCALE = scale_of(DATA_WIDTH, FRAC_W, TOTAL);
  localparam int     PW    = prod_width(CNT_W, SCALE);
  state_t                        state_q;
  logic [CNT_W-1:0]              count_q, cdf_q, c_d;
  logic [CNT_W-1:0]              hist_q [NBINS];
  logic [DATA_WIDTH-1:0]         idx_q, lut_wdata, lut_rdata, mapped;
  logic [PW-1:0]                 prod;
  logic                          accept, counted, lut_valid_q, frame_err_q;
  logic                          m_valid_q, m_user_q, m_last_q;
  logic [OUT_CH*DATA_WIDTH-1:0]  m_data_q;
  assign s_axis_tready = (state_q == WAIT_SOF) || (state_q == ACCUM);
  assign accept        = s_axis_tvalid & s_axis_tready;
  // before SOF only a tuser pixel is counted; inside a frame a tuser pixel is the error case
  assign counted       = accept & ((state_q == WAIT_SOF) ? s_axis_tuser : !s_axis_tuser);
  assign c_d           = cdf_q + hist_q[idx_q];
  assign prod          = PW'(c_d) * PW'(SCALE);
  assign lut_wdata     = DATA_WIDTH'(sat(64'(prod >> FRAC_W), DATA_WIDTH));
`ifdef HIST_EQ_BYPASS_EN
  assign mapped        = i_bypass ? s_axis_tdata : lut_rdata;
`else
  assign mapped        = lut_rdata;
`endif
  hist_eq_lut #(.DW(DATA_WIDTH)) u_lut (
    .clk_i   (i_sys_clk),
    .we_i    (state_q == CDF),
    .waddr_i (idx_q),
    .wdata_i (lut_wdata),
    .raddr_i (s_axis_tdata),
    .valid_i (lut_valid_q),
    .rdata_o (lut_rdata)
  );
  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn)
    if (!i_sys_aresetn) begin
      state_q     <= WAIT_SOF;
      count_q     <= '0;
      idx_q       <= '0;
      cdf_q       <= '0;
      lut_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        WAIT_SOF: if (accept && s_axis_tuser) begin
          count_q <= CNT_W'(1);
          state_q <= ACCUM;
        end
        ACCUM: if (accept) begin
          if (s_axis_tuser) begin
            frame_err_q <= 1'b1;
            state_q     <= CLR;
            idx_q       <= '0;
            count_q     <= '0;
          end else if (count_q == CNT_W'(TOTAL - 1)) begin
            state_q <= CDF;
            idx_q   <= '0;
            cdf_q   <= '0;
            count_q <= '0;
          end else count_q <= count_q + 1'b1;
        end
        CDF: begin
          cdf_q <= c_d;
          idx_q <= idx_q + 1'b1;
          if (idx_q == '1) begin
            lut_valid_q <= 1'b1;
            state_q     <= WAIT_SOF;
          end
        end
        CLR: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == '1) state_q <= WAIT_SOF;
        end
        default: state_q <= WAIT_SOF;
      endcase
    end
  // bins are zeroed as the CDF/CLR sweep passes them, ready for the next frame
  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn)
    if (!i_sys_aresetn) for (int b = 0; b < NBINS; b++) hist_q[b] <= '0;
    else if (counted) hist_q[s_axis_tdata] <= hist_q[s_axis_tdata] + 1'b1;
    else if (state_q == CDF || state_q == CLR) hist_q[idx_q] <= '0;
  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn)
    if (!i_sys_aresetn) begin
      m_valid_q <= 1'b0;
      m_user_q  <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      m_valid_q <= accept;
      m_user_q  <= accept & s_axis_tuser;
      m_last_q  <= accept & s_axis_tlast;
      if (accept) m_data_q <= {OUT_CH{mapped}};
    end
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tlast  = m_last_q;
  assign o_lut_valid   = lut_valid_q;
  assign o_frame_err   = frame_err_q;
endmodule

// File: tb/tb_hist_eq_stream.sv
// tb_hist_eq_stream: directed stimulus with a frame-level equalisation model and per-cycle output compare
module tb_hist_eq_stream;
  localparam int     TOTAL = 8;
  localparam longint SCALE = 2088960;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0, s_tready;
  logic [23:0] m_tdata;
  logic        m_tvalid, m_tuser, m_tlast, lut_valid, frame_err;
  logic        bypass = 1'b0;
  typedef struct {
    logic [7:0] d;
    logic       u, l, e, lv;
  } exp_t;
  exp_t       q[$];
  exp_t       ce;
  int         total = 0, bad = 0;
  logic [7:0] m_lut [256];
  bit         m_lv = 0, in_frame = 0;
  int         frame[$];
  hist_eq_stream #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(2), .OUT_CH(3), .FRAC_W(16)) dut (
    .i_sys_clk     (clk),
    .i_sys_aresetn (rst_n),
`ifdef HIST_EQ_BYPASS_EN
    .i_bypass      (bypass),
`endif
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .o_lut_valid   (lut_valid),
    .o_frame_err   (frame_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // equalisation LUT from a complete frame: cumulative count scaled to full range, clamped
  task automatic build_lut();
    int     h[256];
    longint cum, v;
    foreach (h[i]) h[i] = 0;
    foreach (frame[i]) h[frame[i]]++;
    cum = 0;
    for (int i = 0; i < 256; i++) begin
      cum += h[i];
      v = (cum * SCALE) >> 16;
      m_lut[i] = v > 255 ? 8'd255 : 8'(v);
    end
    m_lv = 1;
    in_frame = 0;
    frame.delete();
  endtask
  task automatic model_accept(input int pix, input bit u);
    if (!in_frame) begin
      if (u) begin
        in_frame = 1;
        frame = {pix};
      end
    end else if (u) begin
      in_frame = 0;
      frame.delete();
    end else begin
      frame.push_back(pix);
      if (frame.size() == TOTAL) build_lut();
    end
  endtask
  task automatic send(input int pix, input bit u, input bit l, input int pin);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    s_tdata = 8'(pix); s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    while (!s_tready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      chk("ready_timeout", 0, 1);
      s_tvalid = 1'b0;
      return;
    end
    e.d  = bypass ? 8'(pix) : (m_lv ? m_lut[pix] : 8'(pix));
    e.u  = u;
    e.l  = l;
    e.e  = in_frame && u;
    e.lv = m_lv;
    if (pin >= 0) chk("model_pin", e.d, pin);
    q.push_back(e);
    model_accept(pix, u);
    @(posedge clk);
    #1 s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    @(negedge clk);
    chk("latency", m_tvalid, 1);
  endtask
  task automatic frame_const(input int pix, input int pin);
    for (int i = 0; i < TOTAL; i++) send(pix, i == 0, i % 4 == 3, pin);
  endtask
  task automatic stall(input int expn);
    int n;
    n = 0;
    while (!s_tready && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("stall_cycles", n, expn);
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (m_tvalid) begin
        if (q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          ce = q.pop_front();
          chk("tdata", m_tdata, {ce.d, ce.d, ce.d});
          chk("tuser", m_tuser, ce.u);
          chk("tlast", m_tlast, ce.l);
          chk("frame_err", frame_err, ce.e);
          chk("lut_valid_out", lut_valid, ce.lv);
        end
      end else chk("frame_err_idle", frame_err, 0);
    end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_lut_valid", lut_valid, 0);
    chk("rst_ready", s_tready, 1);
    rst_n = 1'b1;
    frame_const(37, 37);
    stall(256);
    chk("lut_valid_after_f1", lut_valid, 1);
    frame_const(100, 255);
    stall(256);
    send(100, 0, 0, 255);
    send(50, 0, 0, 0);
    for (int i = 0; i < TOTAL; i++) send(i, i == 0, i % 4 == 3, 0);
    stall(256);
    send(0, 1, 0, 31);
    send(3, 0, 0, 127);
    send(7, 0, 0, 255);
    send(200, 0, 1, 255);
    send(1, 0, 0, 63);
    send(5, 1, 0, 191);
    stall(256);
    chk("lut_valid_after_err", lut_valid, 1);
    send(0, 0, 0, 31);
    send(3, 0, 0, 127);
`ifdef HIST_EQ_BYPASS_EN
    frame_const(100, 255);
    stall(256);
    bypass = 1'b1;
    send(100, 0, 0, 100);
    bypass = 1'b0;
    send(100, 0, 0, 255);
`endif
    frame_const(9, -1);
    repeat (99) @(negedge clk);
    chk("cdf_ready_low", s_tready, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midcdf_rst_tvalid", m_tvalid, 0);
    chk("midcdf_rst_tdata", m_tdata, 0);
    chk("midcdf_rst_lut_valid", lut_valid, 0);
    chk("midcdf_rst_err", frame_err, 0);
    m_lv = 0;
    in_frame = 0;
    frame.delete();
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", s_tready, 1);
    send(9, 0, 0, 9);
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
